// File: rtl/count_mon_pkg.sv
// Shared constants and types for the up/down counter monitor and its predictor.
package count_mon_pkg;

  localparam int WIDTH_DEF    = 6;
  localparam int ERR_W_DEF    = 8;
  localparam int SYNC_LEN_DEF = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SYNC  = 2'd1,
    S_TRACK = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/count_predict.sv
// Combinational next-value predictor for the up/down counter contract.
module count_predict
  import count_mon_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] prev_count,
  input  logic             prev_trig,
  input  logic             prev_ctrl,
  output logic [WIDTH-1:0] pred,
  output logic             wrap_cond
);

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;

  // wrap_cond flags a step that legally crosses the max/zero boundary
  always_comb begin
    pred      = prev_count;
    wrap_cond = 1'b0;
    if (prev_trig) begin
      if (prev_ctrl == DIR_DOWN) begin
        pred      = prev_count - WIDTH'(1);
        wrap_cond = (prev_count == CNT_ZERO);
      end else begin
        pred      = prev_count + WIDTH'(1);
        wrap_cond = (prev_count == CNT_MAX);
      end
    end
  end

endmodule

// File: rtl/count_monitor.sv
// Passive checker that locks onto an up/down counter stream and tallies tracking errors.
module count_monitor
  import count_mon_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int ERR_W    = ERR_W_DEF,
  parameter int SYNC_LEN = SYNC_LEN_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trig,
  input  logic             ctrl,
  input  logic [WIDTH-1:0] count,
  output logic             locked,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected,
  output logic             wrap
);

  localparam logic [3:0]       SYNC_TARGET = 4'(SYNC_LEN);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  logic [WIDTH-1:0] prev_count_reg;
  logic             prev_trig_reg;
  logic             prev_ctrl_reg;
  state_t           state_reg;
  logic [3:0]       match_cnt_reg;
  logic [3:0]       match_cnt_next;
  logic [WIDTH-1:0] pred;
  logic             wrap_cond;
  logic             hit;

  count_predict #(
    .WIDTH(WIDTH)
  ) u_predict (
    .prev_count(prev_count_reg),
    .prev_trig (prev_trig_reg),
    .prev_ctrl (prev_ctrl_reg),
    .pred      (pred),
    .wrap_cond (wrap_cond)
  );

  assign hit            = (count == pred);
  assign match_cnt_next = match_cnt_reg + 4'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_count_reg <= '0;
      prev_trig_reg  <= 1'b0;
      prev_ctrl_reg  <= 1'b0;
      state_reg      <= S_IDLE;
      match_cnt_reg  <= 4'd0;
      locked         <= 1'b0;
      mismatch       <= 1'b0;
      err_count      <= '0;
      expected       <= '0;
      wrap           <= 1'b0;
    end else begin
      // the observed sample always becomes the reference, so re-sync starts from it
      prev_count_reg <= count;
      prev_trig_reg  <= trig;
      prev_ctrl_reg  <= ctrl;
      expected       <= pred;
      mismatch       <= 1'b0;
      wrap           <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          state_reg <= S_SYNC;
        end
        S_SYNC: begin
          if (hit) begin
            match_cnt_reg <= match_cnt_next;
            if (match_cnt_next >= SYNC_TARGET) begin
              state_reg <= S_TRACK;
              locked    <= 1'b1;
            end
          end else begin
            match_cnt_reg <= 4'd0;
          end
        end
        S_TRACK: begin
          if (hit) begin
            wrap <= wrap_cond;
          end else begin
            mismatch      <= 1'b1;
            locked        <= 1'b0;
            match_cnt_reg <= 4'd0;
            state_reg     <= S_SYNC;
            if (err_count != ERR_MAX) begin
              err_count <= err_count + ERR_W'(1);
            end
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_monitor.sv
// Table-driven, directed and randomized checks of count_monitor against a behavioural model.
module tb_count_monitor;

  localparam int W   = 6;
  localparam int EW  = 8;
  localparam int SL  = 2;
  localparam int MOD = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          trig = 1'b0;
  logic          ctrl = 1'b0;
  logic [W-1:0]  count = '0;
  logic          locked;
  logic          mismatch;
  logic [EW-1:0] err_count;
  logic [W-1:0]  expected;
  logic          wrap;

  count_monitor #(.WIDTH(W), .ERR_W(EW), .SYNC_LEN(SL)) dut (
    .clk(clk), .reset(reset), .trig(trig), .ctrl(ctrl), .count(count),
    .locked(locked), .mismatch(mismatch), .err_count(err_count),
    .expected(expected), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // behavioural model: phase 0 = first sample after reset, 1 = hunting, 2 = locked
  int m_phase = 0, m_streak = 0, m_err = 0, m_prev = 0;
  bit m_pt = 0, m_pc = 0;
  int m_locked = 0, m_mm = 0, m_exp = 0, m_wrap = 0;

  int cur = 0;

  typedef struct {
    logic       r, t, c;
    logic [5:0] cnt;
    int         lk, mm, err, ex, wr;
  } vec_t;

  vec_t vecs[14];

  function automatic int adv(int v, bit t, bit c);
    int d;
    d = t ? (c ? -1 : 1) : 0;
    return (v + d + MOD) % MOD;
  endfunction

  task automatic model(input logic r, input logic t, input logic c, input int cnt);
    int pred, diff;
    if (!r) begin
      m_phase = 0; m_streak = 0; m_err = 0; m_prev = 0; m_pt = 0; m_pc = 0;
      m_locked = 0; m_mm = 0; m_exp = 0; m_wrap = 0;
      return;
    end
    pred  = adv(m_prev, m_pt, m_pc);
    m_exp = pred; m_mm = 0; m_wrap = 0;
    if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (cnt == pred) begin
        m_streak++;
        if (m_streak >= SL) begin m_phase = 2; m_locked = 1; end
      end else begin
        m_streak = 0;
      end
    end else begin
      if (cnt != pred) begin
        m_mm = 1; m_locked = 0; m_phase = 1; m_streak = 0;
        if (m_err < 255) m_err++;
      end else begin
        diff   = cnt - m_prev;
        m_wrap = (m_pt && (diff == 63 || diff == -63)) ? 1 : 0;
      end
    end
    m_prev = cnt; m_pt = t; m_pc = c;
  endtask

  task automatic step(input logic r, input logic t, input logic c, input logic [5:0] cnt);
    reset = r; trig = t; ctrl = c; count = cnt;
    @(posedge clk);
    #1;
    model(r, t, c, int'(cnt));
    n_vec++;
    if (int'(locked) != m_locked || int'(mismatch) != m_mm || int'(err_count) != m_err ||
        int'(expected) != m_exp || int'(wrap) != m_wrap) begin
      n_bad++;
      $display("FAIL model r=%0b t=%0b c=%0b cnt=%0d: got lk=%0d mm=%0d err=%0d ex=%0d wr=%0d, required lk=%0d mm=%0d err=%0d ex=%0d wr=%0d",
               r, t, c, cnt, locked, mismatch, err_count, expected, wrap,
               m_locked, m_mm, m_err, m_exp, m_wrap);
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic run(input logic t, input logic c, input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, t, c, 6'(cur));
      cur = adv(cur, t, c);
    end
  endtask

  task automatic fault(input int off);
    step(1'b1, 1'b1, 1'b0, 6'((cur + off) % MOD));
    cur = adv((cur + off) % MOD, 1'b1, 1'b0);
  endtask

  initial begin
    // {r, t, c, cnt, locked, mismatch, err, expected, wrap}
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 6'd0,  0, 0, 0, 0,  0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 6'd0,  0, 0, 0, 0,  0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 6'd1,  0, 0, 0, 1,  0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 6'd2,  1, 0, 0, 2,  0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 6'd3,  1, 0, 0, 3,  0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 6'd4,  1, 0, 0, 4,  0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 6'd9,  0, 1, 1, 5,  0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 6'd10, 0, 0, 1, 10, 0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 6'd11, 1, 0, 1, 11, 0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 6'd11, 1, 0, 1, 11, 0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 6'd11, 1, 0, 1, 11, 0};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 6'd10, 1, 0, 1, 10, 0};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 6'd9,  1, 0, 1, 9,  0};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 6'd8,  0, 0, 0, 0,  0};

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].r, vecs[i].t, vecs[i].c, vecs[i].cnt);
      n_vec++;
      if (int'(locked) != vecs[i].lk || int'(mismatch) != vecs[i].mm ||
          int'(err_count) != vecs[i].err || int'(expected) != vecs[i].ex ||
          int'(wrap) != vecs[i].wr) begin
        n_bad++;
        $display("FAIL table[%0d]: got lk=%0d mm=%0d err=%0d ex=%0d wr=%0d, required lk=%0d mm=%0d err=%0d ex=%0d wr=%0d",
                 i, locked, mismatch, err_count, expected, wrap,
                 vecs[i].lk, vecs[i].mm, vecs[i].err, vecs[i].ex, vecs[i].wr);
      end
    end

    // up wrap 63->0, then down wrap 0->63, then hold at 62
    step(1'b0, 1'b0, 1'b0, 6'd0);
    cur = 60;
    run(1'b1, 1'b0, 4);
    chk("up_locked", int'(locked), 1);
    run(1'b1, 1'b0, 1);
    chk("up_wrap", int'(wrap), 1);
    run(1'b1, 1'b0, 1);
    chk("up_wrap_end", int'(wrap), 0);
    run(1'b1, 1'b1, 3);
    chk("down_pre_wrap", int'(wrap), 0);
    run(1'b1, 1'b1, 1);
    chk("down_wrap", int'(wrap), 1);
    run(1'b0, 1'b1, 1);
    chk("hold_val", int'(expected), 62);
    chk("down_wrap_end", int'(wrap), 0);
    run(1'b0, 1'b1, 3);
    chk("hold_locked", int'(locked), 1);
    chk("hold_no_mm", int'(mismatch), 0);

    // 10 -> 14 fault while locked, then relock from the observed value
    step(1'b0, 1'b0, 1'b0, 6'd0);
    cur = 8;
    run(1'b1, 1'b0, 3);
    chk("pre_fault_locked", int'(locked), 1);
    step(1'b1, 1'b1, 1'b0, 6'd14);
    cur = 15;
    chk("fault_mm", int'(mismatch), 1);
    chk("fault_err", int'(err_count), 1);
    chk("fault_unlock", int'(locked), 0);
    chk("fault_exp", int'(expected), 11);
    run(1'b1, 1'b0, 1);
    chk("mm_pulse_len", int'(mismatch), 0);
    chk("resync_1", int'(locked), 0);
    run(1'b1, 1'b0, 1);
    chk("resync_2", int'(locked), 1);

    // saturation of the error tally
    step(1'b0, 1'b0, 1'b0, 6'd0);
    cur = 0;
    run(1'b1, 1'b0, 3);
    for (int k = 0; k < 300; k++) begin
      fault(5);
      run(1'b1, 1'b0, 2);
      if (k == 254) chk("err_at_255", int'(err_count), 255);
    end
    chk("err_saturated", int'(err_count), 255);
    fault(7);
    chk("err_sat_mm", int'(mismatch), 1);
    chk("err_stays", int'(err_count), 255);

    // reset while locked with five errors
    step(1'b0, 1'b0, 1'b0, 6'd0);
    cur = 20;
    run(1'b1, 1'b0, 3);
    for (int k = 0; k < 5; k++) begin
      fault(3);
      run(1'b1, 1'b0, 2);
    end
    chk("err_five", int'(err_count), 5);
    chk("locked_before_rst", int'(locked), 1);
    step(1'b0, 1'b1, 1'b0, 6'(cur));
    chk("rst_locked", int'(locked), 0);
    chk("rst_err", int'(err_count), 0);
    chk("rst_expected", int'(expected), 0);
    chk("rst_mm", int'(mismatch), 0);
    cur = 33;
    run(1'b1, 1'b1, 2);
    chk("relock_early", int'(locked), 0);
    run(1'b1, 1'b1, 1);
    chk("relock", int'(locked), 1);

    // randomized stream with occasional corruption and resets
    cur = 0;
    for (int i = 0; i < 3000; i++) begin
      logic r, t, c;
      int   cnt;
      r   = ($urandom_range(0, 299) != 0);
      t   = ($urandom_range(0, 3) != 0);
      c   = $urandom_range(0, 1);
      cnt = cur;
      if ($urandom_range(0, 24) == 0) cnt = cur ^ int'($urandom_range(1, 63));
      step(r, t, c, 6'(cnt));
      cur = adv(cnt, t, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/count_monitor.md
Name: count_monitor

Overview:
- Passive checker on the consuming side of the 6-bit up/down counter interface (count, trig, ctrl).
- Each cycle it predicts the counter's next value from the previous sample, compares it with the observed count, and locks onto a consistent stream.
- It flags mismatches, keeps a saturating error tally, and reports wrap-arounds.
- It sits beside the counter in the datapath and in benches as a self-checking monitor.

Parameters:
- WIDTH, 6, width of the monitored count bus.
- ERR_W, 8, width of the saturating error counter.
- SYNC_LEN, 2, consecutive matching samples required to declare lock (range 1..15).

Ports:
- clk  input  1  rising-edge clock, shared with the counter.
- reset  input  1  synchronous, active-low reset.
- trig  input  1  counter enable as driven to the counter.
- ctrl  input  1  counter direction as driven to the counter: 0 = up, 1 = down.
- count  input  WIDTH  observed counter output.
- locked  output  1  high while tracking a consistent stream.
- mismatch  output  1  one-cycle pulse on a tracking error.
- err_count  output  ERR_W  saturating count of tracking errors.
- expected  output  WIDTH  registered prediction for the current cycle's count.
- wrap  output  1  one-cycle pulse on a legal wrap (max->0 up, 0->max down) while locked.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low, on ports named clk and reset. It is sampled only at the rising edge of clk.
- Reset values: all outputs 0. Internal prev_count/prev_trig/prev_ctrl = 0, match_cnt = 0, state = IDLE.
- Counter contract checked: count(n) = count(n-1) + 1 if trig(n-1)=1 and ctrl(n-1)=0. Also count(n) = count(n-1) - 1 if trig(n-1)=1 and ctrl(n-1)=1. Otherwise count(n) = count(n-1). All arithmetic is modulo 2^WIDTH.
- Every cycle out of reset, the block registers count, trig and ctrl into prev_*.
- pred = f(prev_*), computed combinationally. expected is registered as pred.
- State IDLE: first cycle after reset release. Capture the sample only, no compare. Go to SYNC.
- State SYNC:
  - count==pred: match_cnt++. When match_cnt reaches SYNC_LEN, go to TRACK and set locked=1 on the same edge.
  - count!=pred: match_cnt=0, stay in SYNC. No mismatch pulse, err_count unchanged.
- State TRACK:
  - count==pred: stay in TRACK.
  - count!=pred: pulse mismatch for one cycle. err_count++ (saturates at 2^ERR_W-1, never wraps). Clear locked and match_cnt. Go to SYNC.
- Latency: a bad sample in cycle n produces mismatch=1 and locked=0 in cycle n+1. The faulty sample becomes prev_count, so re-sync starts from the observed value.
- wrap: asserted in cycle n+1 only when state is TRACK, the cycle-n compare matched, and one of these holds:
  - prev_count=max, prev_trig=1, prev_ctrl=0, count=0.
  - prev_count=0, prev_trig=1, prev_ctrl=1, count=max.
- Simultaneous events: a direction change together with trig is predicted from the prev_ctrl sampled the cycle before. trig=0 means hold is expected regardless of ctrl.
- Reset mid-operation: any cycle with reset=0 forces the reset values above. This includes err_count and locked, overriding any pending pulse.
- Outputs are registered only. There are no combinational paths from inputs to outputs.

Decomposition:
- Shared package count_mon_pkg holds:
  - state encoding constants S_IDLE=2'd0, S_SYNC=2'd1, S_TRACK=2'd2;
  - DIR_UP=1'b0, DIR_DOWN=1'b1;
  - the default WIDTH/ERR_W/SYNC_LEN values.
- One natural sub-module, count_predict: purely combinational next-value predictor (prev_count, prev_trig, prev_ctrl -> pred, wrap_cond). It is reused by the counter's own assertions.
- The state machine, match counter and saturating error counter stay in count_monitor.

Test Plan:
- Reset, then trig=1/ctrl=0 driving a correct up count from 0 -> locked=1 in the cycle after SYNC_LEN matches (3rd cycle after release), mismatch never asserted, err_count=0.
- Locked up count with 63->0 under trig=1 -> wrap=1 for exactly one cycle, the cycle after count=0 is presented.
- Locked, ctrl=1 with a correct down count through 0->63 -> wrap pulse. Then trig=0 with count held at 62 -> stays locked, no mismatch.
- Locked, count forced from 10 to 14 (expected 11) -> mismatch=1 one cycle later, err_count=1, locked=0. Relocks after 2 correct steps from 14.
- Inject 300 isolated faults with ERR_W=8 -> err_count stops at 255 and stays 255.
- Assert reset=0 for one cycle while locked with err_count=5 -> next cycle all outputs 0, state IDLE. Lock reacquired after release.
